// File: rtl/sparc_mpu.sv
// sparc_mpu: multicycle SPARC-V8-subset processor with internal RAM.
// The control unit (two-process FSM) sequences a datapath with PC/NPC, IR,
// MAR, MDR, a 32x32 register file, ALU/shifter, icc flags (CNVZ), a branch
// condition tester and a byte-addressed big-endian RAM that the environment
// preloads (it is never cleared by reset).
// Ports:
//   Clk    - clock, rising edge
//   Clr    - asynchronous active-high reset
//   State  - current control-unit state code
//   IROut  - instruction register
//   MAROut - memory address register
module sparc_mpu #(
    parameter int MEM_BYTES  = 512,
    parameter int HALT_STATE = 127
) (
    input  logic        Clk,
    input  logic        Clr,
    output logic [6:0]  State,
    output logic [31:0] IROut,
    output logic [31:0] MAROut
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [6:0] {
        S_RESET  = 7'd0,
        S_FETCH  = 7'd1,
        S_FWAIT  = 7'd2,
        S_DECODE = 7'd3,
        S_ALU    = 7'd4,
        S_MADDR  = 7'd5,
        S_LWAIT  = 7'd6,
        S_SWAIT  = 7'd7,
        S_BRANCH = 7'd8,
        S_CALL   = 7'd9,
        S_JMPL   = 7'd10,
        S_SETHI  = 7'd11,
        S_UPD    = 7'd12,
        S_HALT   = 7'(HALT_STATE)
    } state_t;

    state_t state_q, state_d;

    logic [31:0] pc_q, npc_q, ir_q, mar_q, mdr_q, tgt_q;
    logic [3:0]  flags_q;                 // {C, N, V, Z}
    logic        take_q, annul_q, moc_q;
    logic [31:0] rf_q [32];
    logic [7:0]  mem [MEM_BYTES];

    // instruction fields
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  cond;
    logic        imm, abit;
    assign op   = ir_q[31:30];
    assign op2  = ir_q[24:22];
    assign op3  = ir_q[24:19];
    assign rd   = ir_q[29:25];
    assign rs1  = ir_q[18:14];
    assign rs2  = ir_q[4:0];
    assign imm  = ir_q[13];
    assign cond = ir_q[28:25];
    assign abit = ir_q[29];

    logic [31:0] rs1v, rdv, op2v;
    assign rs1v = rf_q[rs1];
    assign rdv  = rf_q[rd];
    assign op2v = imm ? {{19{ir_q[12]}}, ir_q[12:0]} : rf_q[rs2];

    // opcode classes
    logic is_alu, is_shift, is_mem, is_load;
    assign is_alu   = (op3[5] == 1'b0) && !op3[3] && (op3[2:0] != 3'd7);
    assign is_shift = (op3[5:2] == 4'b1001) && (op3[1:0] != 2'd0);
    assign is_mem   = (op3 == 6'h00) || (op3 == 6'h01) || (op3 == 6'h09) ||
                      (op3 == 6'h04) || (op3 == 6'h05);
    assign is_load  = !op3[2];

    // ALU / shifter
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (op3[5]) begin
            case (op3[1:0])
                2'd1:    alu_res = rs1v << op2v[4:0];
                2'd2:    alu_res = rs1v >> op2v[4:0];
                default: alu_res = 32'($signed(rs1v) >>> op2v[4:0]);
            endcase
        end else begin
            case (op3[2:0])
                3'd0: begin
                    {alu_c, alu_res} = {1'b0, rs1v} + {1'b0, op2v};
                    alu_v = (rs1v[31] == op2v[31]) && (alu_res[31] != rs1v[31]);
                end
                3'd4: begin
                    alu_res = rs1v - op2v;
                    alu_c   = rs1v < op2v;          // borrow
                    alu_v   = (rs1v[31] != op2v[31]) && (alu_res[31] != rs1v[31]);
                end
                3'd1:    alu_res = rs1v & op2v;
                3'd2:    alu_res = rs1v | op2v;
                3'd3:    alu_res = rs1v ^ op2v;
                3'd5:    alu_res = rs1v & ~op2v;
                default: alu_res = rs1v | ~op2v;
            endcase
        end
    end

    // icc condition tester: codes 8..15 are the negations of 0..7
    logic fc, fn, fv, fz, cbase, taken;
    assign {fc, fn, fv, fz} = flags_q;
    always_comb begin
        case (cond[2:0])
            3'd0:    cbase = 1'b0;
            3'd1:    cbase = fz;
            3'd2:    cbase = fz | (fn ^ fv);
            3'd3:    cbase = fn ^ fv;
            3'd4:    cbase = fc | fz;
            3'd5:    cbase = fc;
            3'd6:    cbase = fn;
            default: cbase = fv;
        endcase
    end
    assign taken = cond[3] ? ~cbase : cbase;

    // memory handshake: MOV from the CU, MOC one edge later
    logic       mov, mem_rd, mem_go, ld_sext;
    logic [1:0] mem_type;
    always_comb begin
        mov      = 1'b0;
        mem_rd   = 1'b1;
        mem_type = 2'd2;
        case (state_q)
            S_FWAIT: mov = 1'b1;
            S_LWAIT: begin
                mov      = 1'b1;
                mem_type = (op3 == 6'h00) ? 2'd2 : 2'd0;
            end
            S_SWAIT: begin
                mov      = 1'b1;
                mem_rd   = 1'b0;
                mem_type = (op3 == 6'h04) ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
    end
    assign mem_go  = mov & ~moc_q;
    assign ld_sext = (state_q == S_LWAIT) && op3[3];

    logic [AW-1:0] a0, a1, a2, a3;
    assign a0 = mar_q[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);

    logic [31:0] rdata;
    always_comb begin
        case (mem_type)
            2'd2:    rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
            2'd1:    rdata = {{16{ld_sext & mem[a0][7]}}, mem[a0], mem[a1]};
            default: rdata = {{24{ld_sext & mem[a0][7]}}, mem[a0]};
        endcase
    end

    // RAM has no reset; store data is taken straight from rd, which is
    // also what MDR captures on the same edge.
    always_ff @(posedge Clk) begin
        if (mem_go && !mem_rd) begin
            if (mem_type == 2'd2) begin
                mem[a0] <= rdv[31:24];
                mem[a1] <= rdv[23:16];
                mem[a2] <= rdv[15:8];
                mem[a3] <= rdv[7:0];
            end else if (mem_type == 2'd1) begin
                mem[a0] <= rdv[15:8];
                mem[a1] <= rdv[7:0];
            end else begin
                mem[a0] <= rdv[7:0];
            end
        end
    end

    // register file write port
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd;
        rf_wd = '0;
        case (state_q)
            S_ALU:   begin rf_we = 1'b1;  rf_wd = alu_res; end
            S_LWAIT: begin rf_we = moc_q; rf_wd = mdr_q;   end
            S_CALL:  begin rf_we = 1'b1;  rf_wa = 5'd15; rf_wd = pc_q; end
            S_JMPL:  begin rf_we = 1'b1;  rf_wd = pc_q;    end
            S_SETHI: begin rf_we = 1'b1;  rf_wd = {ir_q[21:0], 10'd0}; end
            default: ;
        endcase
    end

    // control unit
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_FWAIT;
            S_FWAIT:  if (moc_q) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_HALT;
                case (op)
                    2'd0: if (op2 == 3'd2)      state_d = S_BRANCH;
                          else if (op2 == 3'd4) state_d = S_SETHI;
                    2'd1: state_d = S_CALL;
                    2'd2: if (is_alu || is_shift) state_d = S_ALU;
                          else if (op3 == 6'h38)  state_d = S_JMPL;
                    default: if (is_mem) state_d = S_MADDR;
                endcase
            end
            S_ALU:    state_d = S_UPD;
            S_MADDR:  state_d = is_load ? S_LWAIT : S_SWAIT;
            S_LWAIT:  if (moc_q) state_d = S_UPD;
            S_SWAIT:  if (moc_q) state_d = S_UPD;
            S_BRANCH, S_CALL, S_JMPL, S_SETHI: state_d = S_UPD;
            S_UPD:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // datapath
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pc_q    <= '0;
            npc_q   <= 32'd4;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            tgt_q   <= '0;
            flags_q <= '0;
            take_q  <= 1'b0;
            annul_q <= 1'b0;
            moc_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            moc_q <= mem_go;
            if (mem_go) mdr_q <= mem_rd ? rdata : rdv;
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
            case (state_q)
                S_FETCH: begin
                    mar_q   <= pc_q;
                    take_q  <= 1'b0;
                    annul_q <= 1'b0;
                end
                S_FWAIT: if (moc_q) ir_q <= mdr_q;
                S_ALU: if (op3[5:4] == 2'b01)
                    flags_q <= {alu_c, alu_res[31], alu_v, alu_res == 32'd0};
                S_MADDR: mar_q <= rs1v + op2v;
                S_BRANCH: begin
                    tgt_q   <= pc_q + {{8{ir_q[21]}}, ir_q[21:0], 2'b00};
                    take_q  <= taken;
                    // annul on a=1 when not taken, or always for BA
                    annul_q <= abit && (!taken || cond == 4'h8);
                end
                S_CALL: begin
                    tgt_q  <= pc_q + {ir_q[29:0], 2'b00};
                    take_q <= 1'b1;
                end
                S_JMPL: begin
                    tgt_q  <= rs1v + op2v;
                    take_q <= 1'b1;
                end
                S_UPD: begin
                    if (annul_q && take_q) begin
                        pc_q  <= tgt_q;
                        npc_q <= tgt_q + 32'd4;
                    end else if (annul_q) begin
                        pc_q  <= npc_q + 32'd4;
                        npc_q <= npc_q + 32'd8;
                    end else begin
                        pc_q  <= npc_q;
                        npc_q <= take_q ? tgt_q : npc_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign State  = state_q;
    assign IROut  = ir_q;
    assign MAROut = mar_q;
endmodule

// File: tb/tb_sparc_mpu.sv
module tb_sparc_mpu;
    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic [6:0]  State;
    logic [31:0] IROut, MAROut;

    int total = 0;
    int bad   = 0;
    logic [55:0] seqv;

    sparc_mpu #(.MEM_BYTES(512), .HALT_STATE(127)) dut (
        .Clk(Clk), .Clr(Clr), .State(State), .IROut(IROut), .MAROut(MAROut)
    );

    always #5 Clk = ~Clk;

    task automatic put_word(input int a, input logic [31:0] w);
        dut.mem[a]   = w[31:24];
        dut.mem[a+1] = w[23:16];
        dut.mem[a+2] = w[15:8];
        dut.mem[a+3] = w[7:0];
    endtask

    task automatic load_prog();
        for (int i = 0; i < 512; i++) dut.mem[i] = 8'hFF;
        put_word(32'h00, 32'h82002005); // add   r1,r0,5
        put_word(32'h04, 32'h84A06005); // subcc r2,r1,5
        put_word(32'h08, 32'hC2202040); // st    r1,[r0+64]
        put_word(32'h0C, 32'hC6082043); // ldub  r3,[r0+67]
        put_word(32'h10, 32'hC8482044); // ldsb  r4,[r0+68]
        put_word(32'h14, 32'h02800002); // be    +2
        put_word(32'h18, 32'h8A002007); // add   r5,r0,7   (delay slot)
        put_word(32'h1C, 32'h8C902001); // orcc  r6,r0,1
        put_word(32'h20, 32'h22800003); // be,a  +3 (not taken)
        put_word(32'h24, 32'h8E002009); // add   r7,r0,9   (annulled)
        put_word(32'h28, 32'h90A02001); // subcc r8,r0,1
        put_word(32'h2C, 32'h93286004); // sll   r9,r1,4
        put_word(32'h30, 32'h95392004); // sra   r10,r4,4
        put_word(32'h34, 32'h96820001); // addcc r11,r8,r1
        put_word(32'h38, 32'h4000000A); // call  0x60
        put_word(32'h3C, 32'h19012345); // sethi r12,0x12345 (delay slot)
        put_word(32'h40, 32'hAAAAAAAA); // data
        dut.mem[68] = 8'h80;
        put_word(32'h60, 32'h9BC02070); // jmpl  r13,r0+0x70
        put_word(32'h64, 32'h01000000); // nop
    endtask

    // run until the CU returns to FETCH; records the state trail in seqv
    task automatic step();
        logic [6:0] last;
        logic done;
        last = State;
        seqv = '0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk);
            if (State !== last) begin
                seqv = {seqv[48:0], State};
                last = State;
                if (State == 7'd1) done = 1'b1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL step_timeout state=%0d need=1", State);
        end
    endtask

    task automatic test_reset();
        #2 Clr = 1'b1;
        #1;
        total++; if (State !== 7'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", State); end
        total++; if (dut.pc_q !== 32'd0 || dut.npc_q !== 32'd4) begin bad++;
            $display("FAIL rst_pc got=%h/%h exp=0/4", dut.pc_q, dut.npc_q); end
        total++; if (MAROut !== 32'd0 || IROut !== 32'd0) begin bad++;
            $display("FAIL rst_mar_ir got=%h/%h exp=0/0", MAROut, IROut); end
        total++; if (dut.flags_q !== 4'b0000 || dut.rf_q[1] !== 32'd0) begin bad++;
            $display("FAIL rst_flags_r1 got=%b/%h exp=0000/0", dut.flags_q, dut.rf_q[1]); end
        #1 Clr = 1'b0;
        @(negedge Clk);
        total++; if (State !== 7'd1) begin bad++; $display("FAIL rst_edge1 got=%0d exp=1", State); end
        @(negedge Clk);
        total++; if (State !== 7'd2) begin bad++; $display("FAIL rst_edge2 got=%0d exp=2", State); end
    endtask

    task automatic test_alu();
        step();
        total++; if (seqv[27:0] !== {7'd3, 7'd4, 7'd12, 7'd1}) begin bad++;
            $display("FAIL alu_states got=%h exp=%h", seqv[27:0], {7'd3, 7'd4, 7'd12, 7'd1}); end
        total++; if (dut.rf_q[1] !== 32'd5) begin bad++; $display("FAIL alu_r1 got=%h exp=5", dut.rf_q[1]); end
        total++; if (dut.pc_q !== 32'd4 || dut.npc_q !== 32'd8) begin bad++;
            $display("FAIL alu_pc got=%h/%h exp=4/8", dut.pc_q, dut.npc_q); end
        total++; if (IROut !== 32'h82002005) begin bad++; $display("FAIL alu_ir got=%h exp=82002005", IROut); end
        step();
        total++; if (seqv[34:0] !== {7'd2, 7'd3, 7'd4, 7'd12, 7'd1}) begin bad++;
            $display("FAIL subcc_states got=%h", seqv[34:0]); end
        total++; if (dut.rf_q[2] !== 32'd0 || dut.flags_q !== 4'b0001) begin bad++;
            $display("FAIL subcc got=%h/%b exp=0/0001", dut.rf_q[2], dut.flags_q); end
    endtask

    task automatic test_store_load();
        step();
        total++; if (seqv[41:0] !== {7'd2, 7'd3, 7'd5, 7'd7, 7'd12, 7'd1}) begin bad++;
            $display("FAIL st_states got=%h", seqv[41:0]); end
        total++; if ({dut.mem[64], dut.mem[65], dut.mem[66], dut.mem[67]} !== 32'h00000005) begin bad++;
            $display("FAIL st_mem got=%h exp=00000005", {dut.mem[64], dut.mem[65], dut.mem[66], dut.mem[67]}); end
        total++; if (dut.mem[68] !== 8'h80) begin bad++; $display("FAIL st_neighbor got=%h exp=80", dut.mem[68]); end
        step();
        total++; if (dut.rf_q[3] !== 32'd5) begin bad++; $display("FAIL ldub got=%h exp=5", dut.rf_q[3]); end
        total++; if (MAROut !== 32'd67) begin bad++; $display("FAIL ldub_mar got=%h exp=43", MAROut); end
        step();
        total++; if (dut.rf_q[4] !== 32'hFFFFFF80) begin bad++; $display("FAIL ldsb got=%h exp=ffffff80", dut.rf_q[4]); end
    endtask

    task automatic test_branch();
        step(); // be +2, Z=1
        total++; if (dut.pc_q !== 32'h18 || dut.npc_q !== 32'h1C) begin bad++;
            $display("FAIL be_taken got=%h/%h exp=18/1c", dut.pc_q, dut.npc_q); end
        step(); // delay slot
        total++; if (dut.rf_q[5] !== 32'd7 || dut.pc_q !== 32'h1C) begin bad++;
            $display("FAIL be_delay got=%h/%h exp=7/1c", dut.rf_q[5], dut.pc_q); end
        step(); // orcc
        total++; if (dut.rf_q[6] !== 32'd1 || dut.flags_q !== 4'b0000) begin bad++;
            $display("FAIL orcc got=%h/%b exp=1/0000", dut.rf_q[6], dut.flags_q); end
        step(); // be,a not taken
        total++; if (dut.pc_q !== 32'h28 || dut.npc_q !== 32'h2C) begin bad++;
            $display("FAIL bea_annul got=%h/%h exp=28/2c", dut.pc_q, dut.npc_q); end
        step(); // subcc r8
        total++; if (dut.rf_q[7] !== 32'd0 || IROut !== 32'h90A02001) begin bad++;
            $display("FAIL bea_skip got=%h/%h exp=0/90a02001", dut.rf_q[7], IROut); end
        total++; if (dut.rf_q[8] !== 32'hFFFFFFFF || dut.flags_q !== 4'b1100) begin bad++;
            $display("FAIL subcc_borrow got=%h/%b exp=ffffffff/1100", dut.rf_q[8], dut.flags_q); end
    endtask

    task automatic test_shift_add();
        step();
        total++; if (dut.rf_q[9] !== 32'h50) begin bad++; $display("FAIL sll got=%h exp=50", dut.rf_q[9]); end
        step();
        total++; if (dut.rf_q[10] !== 32'hFFFFFFF8) begin bad++; $display("FAIL sra got=%h exp=fffffff8", dut.rf_q[10]); end
        step();
        total++; if (dut.rf_q[11] !== 32'd4 || dut.flags_q !== 4'b1000) begin bad++;
            $display("FAIL addcc_carry got=%h/%b exp=4/1000", dut.rf_q[11], dut.flags_q); end
    endtask

    task automatic test_call_jmpl();
        step();
        total++; if (dut.rf_q[15] !== 32'h38 || dut.pc_q !== 32'h3C || dut.npc_q !== 32'h60) begin bad++;
            $display("FAIL call got=%h/%h/%h exp=38/3c/60", dut.rf_q[15], dut.pc_q, dut.npc_q); end
        step();
        total++; if (dut.rf_q[12] !== 32'h048D1400 || dut.pc_q !== 32'h60) begin bad++;
            $display("FAIL sethi got=%h/%h exp=048d1400/60", dut.rf_q[12], dut.pc_q); end
        step();
        total++; if (dut.rf_q[13] !== 32'h60 || dut.npc_q !== 32'h70) begin bad++;
            $display("FAIL jmpl got=%h/%h exp=60/70", dut.rf_q[13], dut.npc_q); end
        step();
        total++; if (dut.pc_q !== 32'h70 || dut.rf_q[0] !== 32'd0) begin bad++;
            $display("FAIL nop got=%h/%h exp=70/0", dut.pc_q, dut.rf_q[0]); end
    endtask

    task automatic test_halt();
        logic held;
        for (int c = 0; c < 20 && State !== 7'd127; c++) @(negedge Clk);
        total++; if (State !== 7'd127) begin bad++; $display("FAIL halt_enter got=%0d exp=127", State); end
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (State !== 7'd127) held = 1'b0;
        end
        total++; if (!held) begin bad++; $display("FAIL halt_hold got=%0d exp=127", State); end
        Clr = 1'b1;
        #1;
        total++; if (State !== 7'd0 || dut.pc_q !== 32'd0) begin bad++;
            $display("FAIL halt_clr got=%0d/%h exp=0/0", State, dut.pc_q); end
        total++; if (dut.mem[67] !== 8'h05) begin bad++; $display("FAIL ram_kept got=%h exp=05", dut.mem[67]); end
        @(negedge Clk);
        Clr = 1'b0;
    endtask

    initial begin
        load_prog();
        test_reset();
        test_alu();
        test_store_load();
        test_branch();
        test_shift_add();
        test_call_jmpl();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparc_mpu.md
Name: sparc_mpu

Overview:
- Multicycle SPARC-V8-subset microprocessor: control unit (FSM) plus datapath (PC/NPC, IR, MAR, MDR, 32x32 register file, ALU, shifter, icc flags, condition tester, 512-byte RAM).
- Self-contained top level. Program and data live in the internal RAM, which the bench preloads hierarchically before the clock starts.
- Exposes the FSM state, the instruction register and MAR for monitoring.

Parameters:
- MEM_BYTES, 512, internal RAM size in bytes (address = MAR[8:0]).
- HALT_STATE, 127, state code entered on an unimplemented opcode.

Ports:
- Clk  input  1  system clock, rising edge active.
- Clr  input  1  reset, asynchronous, active-high.
- State  output  7  current control-unit state code.
- IROut  output  32  instruction register contents.
- MAROut  output  32  memory address register contents.

Behaviour:
- Reset (Clr=1, asynchronous), held until Clr falls:
  - State=0, PC=0, NPC=4, IR=0, MAR=0, MDR=0, flags CNVZ=0000.
  - r1..r31=0; r0 is hardwired to 0.
  - RAM contents are NOT cleared.
- RAM:
  - Byte-addressed, big-endian, internal array mem[0:511].
  - Access handshake: the CU asserts MOV with R/W (1=read) and type (0=byte, 1=halfword, 2=word). MOC rises on the clock edge after MOV; the FSM waits in the current state until MOC=1.
  - Byte reads are zero- or sign-extended per opcode. Addresses wrap modulo 512.
- State codes:
  - 0 RESET -> 1.
  - 1 FETCH: MAR<=PC, start word read -> 2.
  - 2 FETCH_WAIT: on MOC, IR<=MDR -> 3.
  - 3 DECODE: dispatches on op/op2/op3.
  - 4 ALU: rd<=rs1 op (rs2 | simm13 sign-extended). Ops: add, sub, and, or, xor, andn, orn, sll, srl, sra (shift count = operand2[4:0]). The cc variants update CNVZ per SPARC icc rules -> 12.
  - 5 MEM_ADDR: MAR<=rs1+operand2.
    - Load (ld, ldub, ldsb) -> 6; store (st, stb) -> 7.
  - 6 LOAD_WAIT: on MOC, rd<=extended MDR -> 12.
  - 7 STORE_WAIT: MDR<=rd; on MOC -> 12.
  - 8 BRANCH: Bicc, BCOND per the 16 SPARC icc conditions.
    - Taken: nPC<=PC+4*sext(disp22).
    - Annul bit: if a=1 and the branch is not taken, or a=1 with BA, the delay slot is skipped (PC<=NPC+4 path).
    - -> 12.
  - 9 CALL: r15<=PC, target=PC+4*disp30 -> 12.
  - 10 JMPL: rd<=PC, target=rs1+operand2 -> 12.
  - 11 SETHI: rd<=imm22<<10 -> 12. NOP is SETHI 0 to r0.
  - 12 UPDATE_PC: PC<=NPC, NPC<=target or NPC+4 -> 1.
  - 127 HALT: unimplemented opcode; stays until reset.
- Delayed-control-transfer semantics: the PC/NPC pair is always used; the delay-slot instruction executes unless annulled.
- Flag order CNVZ: C=carry (add) / borrow (sub), N=result[31], V=signed overflow, Z=result==0. Logic cc ops clear C and V.
- Writes to r0 are discarded.
- Clr asserted mid-instruction aborts it immediately. A pending memory write is not committed.

Test Plan:
- Reset: pulse Clr at t=2 -> State=0, PC=0, NPC=4, MAROut=0, CNVZ=0000; first clock edge -> State=1, then 2.
- ALU: mem[0..3]=0x82002005 (add r1,r0,5) -> states 1,2,3,4,12; r1=5; PC=4, NPC=8; IROut=0x82002005.
- Flags: next 0x84A06005 (subcc r2,r1,5) -> r2=0, CNVZ=0001.
- Store/load:
  - 0xC2202040 (st r1,[r0+64]) -> mem[64..67]=00,00,00,05.
  - ldub of [r0+67] -> rd=5.
  - ldsb of a byte holding 0x80 -> 0xFFFFFF80.
- Branch: be +2 words with Z=1 -> delay slot executes, then PC=branch+8. With a=1 and Z=0 -> delay slot skipped (no register change).
- Halt: word 0xFFFFFFFF -> State=127 held over 20 cycles. Clr then returns State=0.
